layer_mixer_fade: RTL and testbench
===================================

Name: layer_mixer_fade

Overview:
- Parametrised N-layer pixel compositor for the title, menu and game screens.
- Takes per-layer colour/display pairs from the sprite colour units and picks the highest-priority visible layer per pixel.
- Adds per-layer blink gating from an internal free-running divider, and optional colour-key transparency.
- Applies a frame-stepped fade-to-black / fade-in brightness ramp used for screen transitions; output feeds the VGA colour path.

Parameters:
- N_LAYERS, 8, number of input layers; index 0 has highest priority.
- PIX_W, 16, width of each layer colour word; the top OUT_W bits are the colour.
- OUT_W, 12, output colour width (RGB, OUT_W/3 bits per channel, CH_W=4 at default).
- DIV_W, 28, width of the free-running blink divider.
- KEY_EN, 0, 1 enables colour-key transparency.
- KEY, 12'h000, colour treated as transparent when KEY_EN=1.
- FADE_STEP, 1, brightness levels moved per frame_tick.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- layer_color  in  N_LAYERS*PIX_W  layer i colour at [i*PIX_W +: PIX_W].
- layer_valid  in  N_LAYERS  layer i covers the current pixel.
- layer_mask  in  N_LAYERS  static layer enable.
- blink_en  in  N_LAYERS  enables blink gating for layer i.
- blink_sel  in  N_LAYERS*5  divider bit index controlling the blink rate of layer i.
- bg_color  in  OUT_W  colour used when no layer wins.
- frame_tick  in  1  one-cycle pulse per frame (vsync).
- fade_req  in  1  one-cycle fade command.
- fade_dir  in  1  direction sampled with fade_req: 0 = fade out to black, 1 = fade in.
- color  out  OUT_W  composited, faded pixel colour.
- win_idx  out  clog2(N_LAYERS)  winning layer index.
- hit  out  1  some layer won.
- fade_busy  out  1  fade ramp in progress.
- fade_done  out  1  one-cycle completion pulse.

Behaviour:
- Divider `div_cnt` (DIV_W bits):
  - resets to 0 and increments every clk.
  - wraps from all-ones to 0 with no glitch on blink phases beyond the natural bit toggle.
- Layer i is visible when `~blink_en[i] | div_cnt[blink_sel_i]`.
  - If `blink_sel_i >= DIV_W`, layer i is always visible.
- Layer i is eligible when all of: `layer_valid[i]`, `layer_mask[i]`, visible, and not (KEY_EN and top OUT_W bits == KEY).
- Stage 1 (registered):
  - The lowest eligible index wins.
  - Registers the winner's top OUT_W bits, win index and hit=1.
  - With no eligible layer: bg_color, index 0, hit=0.
- Stage 2 (registered) applies brightness `level` (0..2^CH_W):
  - Each channel out = `(c*level) >> CH_W`, with a (2*CH_W+1)-bit product.
  - At level = 2^CH_W the colour passes through unchanged; at 0 the output is black.
  - win_idx and hit are delayed to stay aligned with color.
- Total latency is 2 clk from inputs to color/win_idx/hit.
- Reset values: color=0, win_idx=0, hit=0, fade_busy=0, fade_done=0, level=2^CH_W, FSM=IDLE, pipeline regs cleared.
- Fade FSM:
  - IDLE (level max):
    - fade_req & dir=0 → FADE_OUT, busy=1.
    - fade_req & dir=1 → stay in IDLE, fade_done pulse next cycle.
  - FADE_OUT: each frame_tick, level = max(level−FADE_STEP, 0). When level reaches 0 → DARK, busy=0, fade_done=1 for one cycle.
  - DARK (level 0):
    - fade_req & dir=1 → FADE_IN, busy=1.
    - fade_req & dir=0 → stay in DARK, fade_done pulse.
  - FADE_IN: each frame_tick, level = min(level+FADE_STEP, 2^CH_W). At max → IDLE, busy=0, fade_done pulse.
- fade_req while busy is ignored (no queueing, no direction change).
- fade_req and frame_tick in the same cycle: the request is accepted and the level does not step until the next frame_tick.
- frame_tick outside FADE_* states has no effect.
- Reset asserted mid-fade: immediate return to IDLE, level max, no fade_done pulse.

Test Plan:
- Layers 2 and 5 valid and masked in, no blink → after 2 clk, color = layer2[15:4], win_idx=2, hit=1. Drop layer 2 → win_idx=5. Drop all → color = bg_color, hit=0.
- blink_en[0]=1, blink_sel_0=3, layer 0 alone valid → hit toggles every 8 clk. blink_sel_0=31 (≥DIV_W) → hit stays 1.
- KEY_EN=1, KEY=000, layer 0 colour 16'h0000 and layer 1 16'hF0F0 → color=12'hF0F, win_idx=1.
- Layer colour 12'hFFF, fade_req dir=0, FADE_STEP=1, 16 frame_ticks → color steps F,E,…,0 per channel (level 8 gives 12'h777). fade_done pulses once with busy falling; a second fade_req dir=0 in DARK gives an immediate done pulse.
- In DARK, fade_req dir=1 plus a same-cycle frame_tick → level still 0, then reaches 16 after 16 further ticks, IDLE, done pulse. fade_req dir=0 issued during FADE_IN is ignored.
- Assert rst_n=0 at level 5 in FADE_OUT → all outputs 0 asynchronously. After release, level=16, IDLE, no done pulse.

Source files
------------

// File: rtl/layer_mixer_fade_if.sv
// rtl/layer_mixer_fade_if.sv - layer inputs, fade control and composited pixel outputs of layer_mixer_fade
//
// master: the producer of layer/fade inputs and consumer of the pixel result.
// slave : the compositor itself.
//   layer_color  N_LAYERS*PIX_W  layer i colour at [i*PIX_W +: PIX_W]
//   layer_valid  N_LAYERS        layer i covers the current pixel
//   layer_mask   N_LAYERS        static layer enable
//   blink_en     N_LAYERS        blink gating enable per layer
//   blink_sel    N_LAYERS*5      divider bit index per layer
//   bg_color     OUT_W           colour when no layer wins
//   frame_tick   1               one pulse per frame
//   fade_req     1               one-cycle fade command
//   fade_dir     1               0 = fade out, 1 = fade in
//   color        OUT_W           composited, faded colour
//   win_idx      IDX_W           winning layer index
//   hit          1               some layer won
//   fade_busy    1               ramp in progress
//   fade_done    1               completion pulse
interface layer_mixer_fade_if #(
    parameter int N_LAYERS = 8,
    parameter int PIX_W    = 16,
    parameter int OUT_W    = 12
);
    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic [N_LAYERS*PIX_W-1:0] layer_color;
    logic [N_LAYERS-1:0]       layer_valid;
    logic [N_LAYERS-1:0]       layer_mask;
    logic [N_LAYERS-1:0]       blink_en;
    logic [N_LAYERS*5-1:0]     blink_sel;
    logic [OUT_W-1:0]          bg_color;
    logic                      frame_tick;
    logic                      fade_req;
    logic                      fade_dir;
    logic [OUT_W-1:0]          color;
    logic [IDX_W-1:0]          win_idx;
    logic                      hit;
    logic                      fade_busy;
    logic                      fade_done;

    modport master (
        output layer_color, layer_valid, layer_mask, blink_en, blink_sel, bg_color,
        output frame_tick, fade_req, fade_dir,
        input  color, win_idx, hit, fade_busy, fade_done
    );

    modport slave (
        input  layer_color, layer_valid, layer_mask, blink_en, blink_sel, bg_color,
        input  frame_tick, fade_req, fade_dir,
        output color, win_idx, hit, fade_busy, fade_done
    );
endinterface

// File: rtl/layer_mixer_fade.sv
// rtl/layer_mixer_fade.sv - N-layer priority compositor with blink gating, colour key and frame-stepped fade
//
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    layer_mixer_fade_if.slave: layer colour/valid/mask/blink inputs, bg_color,
//          frame_tick/fade_req/fade_dir in; color/win_idx/hit/fade_busy/fade_done out
// Latency from layer inputs to color/win_idx/hit is 2 clk.
module layer_mixer_fade #(
    parameter int               N_LAYERS  = 8,
    parameter int               PIX_W     = 16,
    parameter int               OUT_W     = 12,
    parameter int               DIV_W     = 28,
    parameter bit               KEY_EN    = 1'b0,
    parameter logic [OUT_W-1:0] KEY       = '0,
    parameter int               FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    layer_mixer_fade_if.slave   bus
);
    localparam int IDX_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int CH_W   = OUT_W / 3;
    localparam int LVL_W  = CH_W + 1;
    localparam int STEP_C = (FADE_STEP > (2 ** CH_W)) ? (2 ** CH_W) : FADE_STEP;
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(2 ** CH_W);
    localparam logic [LVL_W-1:0] LVL_STEP = LVL_W'(STEP_C);

    // ------------------------------------------------------------------
    // Free-running blink divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-layer eligibility
    // ------------------------------------------------------------------
    logic [N_LAYERS-1:0] eligible;

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
        logic [4:0]       sel;
        logic [OUT_W-1:0] top;
        logic [DIV_W-1:0] div_sh;
        logic             visible;
        logic             keyed;

        assign sel    = bus.blink_sel[g*5 +: 5];
        assign top    = bus.layer_color[g*PIX_W + PIX_W - OUT_W +: OUT_W];
        assign div_sh = div_cnt >> sel;
        // An index past the divider width means "no blink", not "always off".
        assign visible = ~bus.blink_en[g] | (int'(sel) >= DIV_W) | div_sh[0];
        assign keyed   = KEY_EN && (top == KEY);
        assign eligible[g] = bus.layer_valid[g] & bus.layer_mask[g] & visible & ~keyed;
    end

    // ------------------------------------------------------------------
    // Stage 1: priority select
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] s1_col_nxt, s1_col;
    logic [IDX_W-1:0] s1_idx_nxt, s1_idx;
    logic             s1_hit_nxt, s1_hit;

    // Scanned from the top down so that a lower eligible index overwrites
    // a higher one and index 0 ends up with the highest priority.
    always_comb begin
        s1_col_nxt = bus.bg_color;
        s1_idx_nxt = '0;
        s1_hit_nxt = 1'b0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                s1_col_nxt = bus.layer_color[i*PIX_W + PIX_W - OUT_W +: OUT_W];
                s1_idx_nxt = IDX_W'(i);
                s1_hit_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col <= '0;
            s1_idx <= '0;
            s1_hit <= 1'b0;
        end else begin
            s1_col <= s1_col_nxt;
            s1_idx <= s1_idx_nxt;
            s1_hit <= s1_hit_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fade FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    fade_state_t      state, state_nxt;
    logic [LVL_W-1:0] level, level_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            level  <= LVL_MAX;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            done_q <= done_nxt;
        end
    end

    // A request arriving with frame_tick is taken from IDLE/DARK, where the
    // tick is ignored, so the first level step waits for the next tick.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fade_req) begin
                    if (bus.fade_dir) done_nxt  = 1'b1;
                    else              state_nxt = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (bus.frame_tick) begin
                    if (level > LVL_STEP) begin
                        level_nxt = level - LVL_STEP;
                    end else begin
                        level_nxt = '0;
                        state_nxt = DARK;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DARK: begin
                if (bus.fade_req) begin
                    if (bus.fade_dir) state_nxt = FADE_IN;
                    else              done_nxt  = 1'b1;
                end
            end
            FADE_IN: begin
                if (bus.frame_tick) begin
                    if (level < LVL_MAX - LVL_STEP) begin
                        level_nxt = level + LVL_STEP;
                    end else begin
                        level_nxt = LVL_MAX;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = LVL_MAX;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: brightness scaling
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] faded;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [2*CH_W:0] prod;
        assign prod = {{(CH_W+1){1'b0}}, s1_col[c*CH_W +: CH_W]} * {{CH_W{1'b0}}, level};
        // c <= 2^CH_W-1 and level <= 2^CH_W keep the shifted product within CH_W bits.
        assign faded[c*CH_W +: CH_W] = prod[CH_W +: CH_W];
    end

    if (OUT_W > 3 * CH_W) begin : g_pad
        assign faded[OUT_W-1:3*CH_W] = '0;
    end

    logic [OUT_W-1:0] out_col;
    logic [IDX_W-1:0] out_idx;
    logic             out_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_col <= '0;
            out_idx <= '0;
            out_hit <= 1'b0;
        end else begin
            out_col <= faded;
            out_idx <= s1_idx;
            out_hit <= s1_hit;
        end
    end

    assign bus.color     = out_col;
    assign bus.win_idx   = out_idx;
    assign bus.hit       = out_hit;
    assign bus.fade_busy = (state == FADE_OUT) || (state == FADE_IN);
    assign bus.fade_done = done_q;

endmodule

// File: tb/tb_layer_mixer_fade.sv
// tb/tb_layer_mixer_fade.sv - self-checking bench for layer_mixer_fade
module tb_layer_mixer_fade;
    localparam int N  = 8;
    localparam int PW = 16;
    localparam int OW = 12;
    localparam int M_IDLE = 0, M_OUT = 1, M_DARK = 2, M_IN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_mixer_fade_if #(.N_LAYERS(N), .PIX_W(PW), .OUT_W(OW)) bus ();

    layer_mixer_fade #(
        .N_LAYERS(N), .PIX_W(PW), .OUT_W(OW), .DIV_W(28),
        .KEY_EN(1'b1), .KEY(12'h000), .FADE_STEP(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;
    int done_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_div, m_level, m_mode;
    logic [11:0] m1_col, m_col;
    int          m1_idx, m_idx;
    bit          m1_hit, m_hit, m_done;

    logic [11:0] p_col;
    int          p_idx, n_mode, n_lvl;
    bit          p_hit, n_done;

    function automatic void m_pick(input int div, output logic [11:0] c, output int idx, output bit h);
        int          sel;
        logic [11:0] top;
        bit          vis;
        h = 0; idx = 0; c = bus.bg_color;
        for (int i = 0; i < N; i++) begin
            sel = int'(bus.blink_sel[i*5 +: 5]);
            top = bus.layer_color[i*PW + 4 +: 12];
            vis = !bus.blink_en[i] || sel >= 28 || (((div >> sel) & 1) == 1);
            if (!h && bus.layer_valid[i] && bus.layer_mask[i] && vis && top != 12'h000) begin
                h = 1; idx = i; c = top;
            end
        end
    endfunction

    function automatic logic [11:0] m_fade(input logic [11:0] c, input int lvl);
        logic [11:0] r;
        int ch_v;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            ch_v = (int'(c >> (k * 4)) & 15) * lvl / 16;
            r[k*4 +: 4] = 4'(ch_v);
        end
        return r;
    endfunction

    function automatic void m_fsm(input int mode, input int lvl, input bit req, input bit dir,
                                  input bit tk, output int nm, output int nl, output bit dn);
        nm = mode; nl = lvl; dn = 0;
        case (mode)
            M_IDLE: if (req) begin if (dir) dn = 1; else nm = M_OUT; end
            M_DARK: if (req) begin if (!dir) dn = 1; else nm = M_IN; end
            M_OUT:  if (tk) begin
                        nl = (lvl - 1 < 0) ? 0 : lvl - 1;
                        if (nl == 0) begin nm = M_DARK; dn = 1; end
                    end
            default: if (tk) begin
                        nl = (lvl + 1 > 16) ? 16 : lvl + 1;
                        if (nl == 16) begin nm = M_IDLE; dn = 1; end
                    end
        endcase
    endfunction

    always_comb begin
        m_pick(m_div, p_col, p_idx, p_hit);
        m_fsm(m_mode, m_level, bus.fade_req, bus.fade_dir, bus.frame_tick, n_mode, n_lvl, n_done);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 0; m_level <= 16; m_mode <= M_IDLE;
            m1_col <= '0; m1_idx <= 0; m1_hit <= 0;
            m_col <= '0; m_idx <= 0; m_hit <= 0; m_done <= 0;
        end else begin
            m_div  <= (m_div + 1) % (1 << 28);
            m1_col <= p_col; m1_idx <= p_idx; m1_hit <= p_hit;
            m_col  <= m_fade(m1_col, m_level);
            m_idx  <= m1_idx; m_hit <= m1_hit;
            m_level <= n_lvl; m_mode <= n_mode; m_done <= n_done;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("color", bus.color, m_col);
            check("win_idx", bus.win_idx, m_idx);
            check("hit", bus.hit, m_hit);
            check("fade_busy", bus.fade_busy, (m_mode == M_OUT || m_mode == M_IN));
            check("fade_done", bus.fade_done, m_done);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst_n && bus.fade_done) done_seen++;
        end
    endtask

    task automatic set_layer(input int i, input logic [15:0] c);
        bus.layer_color[i*PW +: PW] = c;
    endtask

    task automatic frame(input int gap);
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        cyc(gap);
    endtask

    task automatic request(input bit dir);
        bus.fade_dir = dir;
        bus.fade_req = 1'b1;
        cyc(1);
        bus.fade_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        bit          h0, nh0;
        logic [3:0]  e;
        bus.layer_color = '0;
        bus.layer_valid = '0;
        bus.layer_mask  = '1;
        bus.blink_en    = '0;
        bus.blink_sel   = '0;
        bus.bg_color    = 12'h5A3;
        bus.frame_tick  = 1'b0;
        bus.fade_req    = 1'b0;
        bus.fade_dir    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_color", bus.color, 12'h000);
        check("rst_hit", bus.hit, 0);
        check("rst_busy", bus.fade_busy, 0);
        check("rst_done", bus.fade_done, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cyc(2);

        // priority select
        set_layer(2, 16'hABCD);
        set_layer(5, 16'h1234);
        bus.layer_valid = 8'b0010_0100;
        cyc(1);
        check("lat1_hit", bus.hit, 0);
        cyc(1);
        check("l2_color", bus.color, 12'hABC);
        check("l2_idx", bus.win_idx, 2);
        check("l2_hit", bus.hit, 1);
        bus.layer_mask = 8'b1111_1011;
        cyc(2);
        check("mask_idx", bus.win_idx, 5);
        bus.layer_mask = '1;
        bus.layer_valid = 8'b0010_0000;
        cyc(2);
        check("l5_color", bus.color, 12'h123);
        check("l5_idx", bus.win_idx, 5);
        bus.layer_valid = '0;
        cyc(2);
        check("bg_color", bus.color, 12'h5A3);
        check("bg_hit", bus.hit, 0);
        check("bg_idx", bus.win_idx, 0);

        // blink gating
        set_layer(0, 16'hFFF0);
        bus.layer_valid = 8'b0000_0001;
        bus.blink_en = 8'b0000_0001;
        bus.blink_sel[4:0] = 5'd3;
        cyc(2);
        h0 = bus.hit;
        nh0 = !h0;
        cyc(8);
        check("blink_t8", bus.hit, nh0);
        cyc(8);
        check("blink_t16", bus.hit, h0);
        bus.blink_sel[4:0] = 5'd31;
        cyc(2);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("blink_sel31", bus.hit, 1);
        end
        bus.blink_en = '0;
        bus.blink_sel = '0;

        // colour key
        set_layer(0, 16'h0000);
        set_layer(1, 16'hF0F0);
        bus.layer_valid = 8'b0000_0011;
        cyc(2);
        check("key_color", bus.color, 12'hF0F);
        check("key_idx", bus.win_idx, 1);

        // fade out
        set_layer(0, 16'hFFF0);
        bus.layer_valid = 8'b0000_0001;
        cyc(2);
        check("pre_fade", bus.color, 12'hFFF);
        request(1'b0);
        check("out_busy", bus.fade_busy, 1);
        done_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            frame(2);
            e = (k >= 15) ? 4'h0 : 4'(15 - k);
            check("fade_out_step", bus.color, {e, e, e});
            if (k == 8) check("level8", bus.color, 12'h777);
        end
        check("out_done_once", done_seen, 1);
        check("out_busy_low", bus.fade_busy, 0);

        // second fade-out while dark
        request(1'b0);
        check("dark_done", bus.fade_done, 1);
        cyc(1);
        check("dark_done_low", bus.fade_done, 0);
        check("dark_busy", bus.fade_busy, 0);

        // fade in with same-cycle tick
        done_seen = 0;
        bus.frame_tick = 1'b1;
        request(1'b1);
        bus.frame_tick = 1'b0;
        check("in_busy", bus.fade_busy, 1);
        cyc(2);
        check("in_still_dark", bus.color, 12'h000);
        request(1'b0);
        check("in_ignore", bus.fade_busy, 1);
        for (int k = 1; k <= 16; k++) begin
            frame(2);
            e = 4'(k - 1);
            check("fade_in_step", bus.color, {e, e, e});
        end
        check("in_done_once", done_seen, 1);
        check("in_busy_low", bus.fade_busy, 0);
        check("in_full", bus.color, 12'hFFF);

        // fade-in request while already bright
        request(1'b1);
        check("idle_in_done", bus.fade_done, 1);
        check("idle_in_busy", bus.fade_busy, 0);

        // frame_tick with no fade running
        frame(1);
        frame(1);
        cyc(1);
        check("idle_tick", bus.color, 12'hFFF);

        // reset mid fade-out at level 5
        request(1'b0);
        for (int k = 0; k < 11; k++) frame(1);
        cyc(2);
        check("lvl5_color", bus.color, 12'h444);
        check("lvl5_busy", bus.fade_busy, 1);
        #2;
        rst_n = 1'b0;
        cmp_en = 1'b0;
        #1;
        check("async_color", bus.color, 12'h000);
        check("async_hit", bus.hit, 0);
        check("async_idx", bus.win_idx, 0);
        check("async_busy", bus.fade_busy, 0);
        check("async_done", bus.fade_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        done_seen = 0;
        cyc(1);
        check("post_rst_c0", bus.color, 12'h000);
        cyc(1);
        check("post_rst_full", bus.color, 12'hFFF);
        cyc(6);
        check("post_rst_nodone", done_seen, 0);
        check("post_rst_busy", bus.fade_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
